note_scheduler: RTL and testbench

Arbiter and sequencer that owns the tone generator's note input. It chooses between live keyboard input from the key-decode stage and an autoplay song held in a synchronous song ROM. In autoplay it fetches each entry, holds the note for its length, and inserts a fixed gap before the next entry. It sits between the key-decode and ROM blocks on one side and the buzzer tone generator on the other.

---
 rtl/note_scheduler_pkg.sv | 32 +++
 rtl/note_scheduler_tick_counter.sv | 27 ++
 rtl/note_scheduler.sv | 132 +++++++++++++
 tb/tb_note_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_scheduler_pkg.sv
// Shared constants and types for the note scheduler: note/octave/length widths,
// song ROM entry layout and the sequencer state encoding.
package note_scheduler_pkg;

    localparam int NOTE_BITS   = 4;
    localparam int OCTAVE_BITS = 2;
    localparam int LENGTH_BITS = 3;
    localparam int ENTRY_BITS  = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

    // ROM entry is {octave, note, length}, length in the LSBs
    localparam int LEN_LSB  = 0;
    localparam int NOTE_LSB = LEN_LSB + LENGTH_BITS;
    localparam int OCT_LSB  = NOTE_LSB + NOTE_BITS;

    localparam logic [NOTE_BITS-1:0] REST_NOTE = '0;

    typedef struct packed {
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
    } song_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/note_scheduler_tick_counter.sv
// Loadable down-counter with enable and zero flag; times both note length and
// the inter-note gap. Holds at zero rather than wrapping.
module tick_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/note_scheduler.sv
// Owns the tone generator's note input: passes live keys through in free play,
// or sequences a song from a synchronous ROM with fixed gaps in autoplay.
module note_scheduler
    import note_scheduler_pkg::*;
#(
    parameter  int TICKS_PER_UNIT = 4,
    parameter  int GAP_TICKS      = 2,
    parameter  int SONG_DEPTH     = 8,
    localparam int ADDR_BITS      = $clog2(SONG_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   live_valid,
    input  logic [OCTAVE_BITS-1:0] live_octave,
    input  logic [NOTE_BITS-1:0]   live_note,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [ENTRY_BITS-1:0]  rom_data,
    output logic                   out_valid,
    output logic [OCTAVE_BITS-1:0] out_octave,
    output logic [NOTE_BITS-1:0]   out_note,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W =
        $clog2(((1 << LENGTH_BITS) - 1) * TICKS_PER_UNIT + GAP_TICKS + 1);
    localparam logic [CNT_W-1:0]     TPU       = CNT_W'(TICKS_PER_UNIT);
    localparam logic [CNT_W-1:0]     GAP_LD    = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SONG_DEPTH - 1);

    state_t               state;
    song_entry_t          ent;
    logic                 cnt_zero, cnt_load, cnt_en, aborting, is_last;
    logic [CNT_W-1:0]     cnt_val;
    state_t               adv_state;
    logic [ADDR_BITS-1:0] adv_addr;

    assign ent      = song_entry_t'(rom_data);
    assign aborting = !mode && state != S_IDLE && state != S_DONE;

    // Last entry ends the song; the address never wraps back to 0.
    assign is_last   = (rom_addr == LAST_ADDR);
    assign adv_state = is_last ? S_DONE : S_FETCH;
    assign adv_addr  = is_last ? rom_addr : rom_addr + ADDR_BITS'(1);

    assign cnt_load = mode && ((state == S_LOAD && ent.length != '0) ||
                               (state == S_PLAY && cnt_zero && !pause && GAP_TICKS > 0));
    assign cnt_val  = (state == S_LOAD) ? CNT_W'(ent.length) * TPU - CNT_W'(1) : GAP_LD;
    assign cnt_en   = !pause && (state == S_PLAY || state == S_GAP);

    tick_counter #(.W(CNT_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            out_valid  <= 1'b0;
            out_octave <= '0;
            out_note   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (aborting) begin
                state     <= S_DONE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!mode) begin
                            out_valid  <= live_valid;
                            out_octave <= live_octave;
                            out_note   <= live_note;
                        end else begin
                            out_valid <= 1'b0;
                            if (start) begin
                                rom_addr <= '0;
                                busy     <= 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        if (ent.length == '0) begin
                            state <= S_DONE;
                        end else begin
                            out_octave <= ent.octave;
                            out_note   <= ent.note;
                            out_valid  <= (ent.note != REST_NOTE);
                            state      <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (cnt_zero && !pause) begin
                            out_valid <= 1'b0;
                            if (GAP_TICKS > 0) begin
                                state <= S_GAP;
                            end else begin
                                state    <= adv_state;
                                rom_addr <= adv_addr;
                            end
                        end
                    end
                    S_GAP: begin
                        if (cnt_zero && !pause) begin
                            state    <= adv_state;
                            rom_addr <= adv_addr;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench: free-play vector table plus scoreboarded song traces
// on a GAP_TICKS=2 instance and a GAP_TICKS=0 instance.
module tb_note_scheduler;

    localparam int TPU = 4;

    typedef struct packed {
        logic       v;
        logic [1:0] oct;
        logic [3:0] note;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        logic       rst, mode, lv;
        logic [1:0] lo;
        logic [3:0] ln;
        logic       ev;
        logic [1:0] eo;
        logic [3:0] en;
        logic       cmp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0, mode = 1'b0, start = 1'b0, pause = 1'b0;
    logic live_valid = 1'b0;
    logic [1:0] live_octave = '0;
    logic [3:0] live_note = '0;

    logic [2:0] d_addr, z_addr;
    logic [8:0] d_rom, z_rom;
    logic       d_v, z_v, d_busy, z_busy, d_done, z_done;
    logic [1:0] d_oct, z_oct;
    logic [3:0] d_note, z_note;

    logic [8:0] rom0 [8];
    logic [8:0] rom1 [8];

    exp_t q[$];
    int   sel = 0;
    int   checks = 0, fails = 0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        d_rom <= rom0[d_addr];
        z_rom <= rom1[z_addr];
    end

    note_scheduler #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(2), .SONG_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .pause(pause),
        .live_valid(live_valid), .live_octave(live_octave), .live_note(live_note),
        .rom_addr(d_addr), .rom_data(d_rom), .out_valid(d_v), .out_octave(d_oct),
        .out_note(d_note), .busy(d_busy), .done(d_done)
    );

    note_scheduler #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(0), .SONG_DEPTH(8)) dut0 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .pause(pause),
        .live_valid(live_valid), .live_octave(live_octave), .live_note(live_note),
        .rom_addr(z_addr), .rom_data(z_rom), .out_valid(z_v), .out_octave(z_oct),
        .out_note(z_note), .busy(z_busy), .done(z_done)
    );

    function automatic exp_t mk(input logic v, input int o, input int n,
                                input logic b, input logic d);
        exp_t e;
        e.v = v; e.oct = 2'(o); e.note = 4'(n); e.busy = b; e.done = d;
        return e;
    endfunction

    function automatic logic [8:0] entry(input int o, input int n, input int l);
        return {2'(o), 4'(n), 3'(l)};
    endfunction

    function automatic exp_t obs();
        exp_t g;
        g = (sel != 0) ? {z_v, z_oct, z_note, z_busy, z_done}
                       : {d_v, d_oct, d_note, d_busy, d_done};
        return g;
    endfunction

    task automatic chk(input string nm, input exp_t e, input logic cmp_tone);
        exp_t g;
        g = obs();
        checks++;
        if (g.v !== e.v || g.busy !== e.busy || g.done !== e.done ||
            (cmp_tone && (g.oct !== e.oct || g.note !== e.note))) begin
            fails++;
            $display("FAIL %s: got v=%0b oct=%0d note=%0d busy=%0b done=%0b, want v=%0b oct=%0d note=%0d busy=%0b done=%0b",
                     nm, g.v, g.oct, g.note, g.busy, g.done, e.v, e.oct, e.note, e.busy, e.done);
        end
    endtask

    task automatic push(input int n, input exp_t e);
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Expected per-cycle trace starting with the sample after the start edge.
    task automatic gen(input int s, input int extra0);
        logic [8:0] ent;
        int gap, len;
        gap = (s != 0) ? 0 : 2;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            ent = (s != 0) ? rom1[i] : rom0[i];
            push(2, mk(1'b0, 0, 0, 1'b1, 1'b0));
            len = int'(ent[2:0]);
            if (len == 0) break;
            push(len * TPU + ((i == 0) ? extra0 : 0),
                 mk(ent[6:3] != 4'd0, int'(ent[8:7]), int'(ent[6:3]), 1'b1, 1'b0));
            push(gap, mk(1'b0, 0, 0, 1'b1, 1'b0));
        end
        push(1, mk(1'b0, 0, 0, 1'b1, 1'b0));
        push(1, mk(1'b0, 0, 0, 1'b0, 1'b1));
        push(1, mk(1'b0, 0, 0, 1'b0, 1'b0));
    endtask

    task automatic run(input string nm, input int pf, input int pt);
        exp_t e;
        int edge_i;
        edge_i = 0;
        start = 1'b1;
        while (q.size() > 0) begin
            pause = (edge_i >= pf && edge_i < pt);
            @(posedge clk); #1;
            start = 1'b0;
            e = q.pop_front();
            chk($sformatf("%s[%0d]", nm, edge_i), e, e.v);
            edge_i++;
        end
        pause = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; mode = 1'b1; start = 1'b0; pause = 1'b0; live_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t vt[9];

    initial begin
        // rst, mode, lv, lo, ln, ev, eo, en, cmp
        vt[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  1'b1};
        vt[1] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'd5,  1'b1, 2'd1, 4'd5,  1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 4'd9,  1'b1, 2'd2, 4'd9,  1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b0, 2'd3, 4'd2,  1'b0, 2'd0, 4'd0,  1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 2'd3, 4'd15, 1'b1, 2'd3, 4'd15, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'd5,  1'b0, 2'd0, 4'd0,  1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 4'd5,  1'b0, 2'd0, 4'd0,  1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'd1,  1'b1, 2'd0, 4'd1,  1'b1};
        vt[8] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'd4,  1'b0, 2'd0, 4'd0,  1'b1};

        for (int i = 0; i < 8; i++) begin
            rom0[i] = '0;
            rom1[i] = '0;
        end

        // Free play and reset, one cycle of latency per vector
        sel = 0;
        for (int i = 0; i < 9; i++) begin
            rst = vt[i].rst; mode = vt[i].mode; live_valid = vt[i].lv;
            live_octave = vt[i].lo; live_note = vt[i].ln;
            @(posedge clk); #1;
            chk($sformatf("free[%0d]", i),
                mk(vt[i].ev, int'(vt[i].eo), int'(vt[i].en), 1'b0, 1'b0), vt[i].cmp);
        end
        rst = 1'b0;

        // Basic song with an end marker
        rom0[0] = entry(1, 3, 2);
        rom0[1] = entry(1, 0, 1);
        rom0[2] = entry(2, 7, 1);
        rom0[3] = entry(0, 0, 0);
        do_reset();
        gen(0, 0);
        run("song", -1, -1);

        // Pause for 5 edges inside the first 8-cycle note
        do_reset();
        gen(0, 5);
        run("pause", 5, 10);

        // Abort during the second entry; stray start and live key while busy
        do_reset();
        live_valid = 1'b1; live_octave = 2'd2; live_note = 4'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            start = (e == 5);
            if (e == 16) mode = 1'b0;
            @(posedge clk); #1;
            case (e)
                2:  chk("abort_first", mk(1'b1, 1, 3, 1'b1, 1'b0), 1'b1);
                6:  chk("abort_start_ignored", mk(1'b1, 1, 3, 1'b1, 1'b0), 1'b1);
                15: chk("abort_rest", mk(1'b0, 0, 0, 1'b1, 1'b0), 1'b0);
                16: chk("abort_done_state", mk(1'b0, 0, 0, 1'b1, 1'b0), 1'b0);
                17: chk("abort_done_pulse", mk(1'b0, 0, 0, 1'b0, 1'b1), 1'b0);
                18: chk("abort_live", mk(1'b1, 2, 6, 1'b0, 1'b0), 1'b1);
                default: ;
            endcase
        end
        start = 1'b0;

        // Full depth, no end marker
        for (int i = 0; i < 8; i++) rom0[i] = entry(i % 4, i + 1, 1);
        do_reset();
        gen(0, 0);
        run("depth", -1, -1);
        checks++;
        if (d_addr !== 3'd7) begin
            fails++;
            $display("FAIL depth_addr: got rom_addr=%0d, want 7", d_addr);
        end

        // GAP_TICKS=0 with a maximum-length note
        rom1[0] = entry(1, 4, 7);
        rom1[1] = entry(2, 2, 1);
        rom1[2] = entry(0, 0, 0);
        sel = 1;
        do_reset();
        gen(1, 0);
        run("gap0", -1, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
